// File: rtl/alu_dispatch_if.sv
// Handshake bundle for the ALU dispatch stage: decoded-instruction input side
// and the in1/in2/alu_c output side feeding the ALU.
interface alu_dispatch_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       aluop;
  logic [2:0]       funct3;
  logic             funct7_b30;
  logic             alu_src;
  logic [WIDTH-1:0] rs1_val;
  logic [WIDTH-1:0] rs2_val;
  logic [WIDTH-1:0] imm;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [3:0]       alu_c;

  // The dispatch stage itself: consumes decoded entries, produces ALU operands.
  modport slave (
    input  in_valid, aluop, funct3, funct7_b30, alu_src, rs1_val, rs2_val, imm,
    output in_ready,
    output out_valid, in1, in2, alu_c,
    input  out_ready
  );

  // The surrounding pipeline: upstream decoder plus the downstream ALU consumer.
  modport master (
    output in_valid, aluop, funct3, funct7_b30, alu_src, rs1_val, rs2_val, imm,
    input  in_ready,
    input  out_valid, in1, in2, alu_c,
    output out_ready
  );
endinterface

// File: rtl/alu_dispatch.sv
// Operand/control dispatch ahead of the 64-bit ALU: decodes ALUOp/funct into
// alu_c, picks operand B, and queues legal entries in a small FIFO.
module alu_dispatch #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  parameter  int CNTW  = 8,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  alu_dispatch_if.slave   bus,
  output logic            illegal_o,
  output logic [CNTW-1:0] illegal_cnt_o,
  output logic [PW:0]     count_o
);

  localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       c;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;
  logic            illegal_q, illegal_d;
  logic [CNTW-1:0] illegal_cnt_q, illegal_cnt_d;

  logic            dec_ok;
  logic [3:0]      dec_c;
  logic [WIDTH-1:0] op_b;
  logic            accept, push, pop;
  entry_t          head;

  always_comb begin
    dec_c  = 4'b0000;
    dec_ok = 1'b1;
    case (bus.aluop)
      2'b00: dec_c = 4'b0010;
      2'b01: dec_c = 4'b0110;
      2'b10: begin
        case (bus.funct3)
          // addi shares funct3=000 with add/sub but bit 30 is immediate data there
          3'b000:  dec_c = (bus.funct7_b30 && !bus.alu_src) ? 4'b0110 : 4'b0010;
          3'b111:  dec_c = 4'b0000;
          3'b110:  dec_c = 4'b0001;
          default: dec_ok = 1'b0;
        endcase
      end
      default: dec_ok = 1'b0;
    endcase
  end

  assign op_b         = bus.alu_src ? bus.imm : bus.rs2_val;
  assign bus.in_ready = (count_q < FULL);
  assign accept       = bus.in_valid && bus.in_ready;
  assign push         = accept && dec_ok && !flush_i;
  assign pop          = bus.out_valid && bus.out_ready && !flush_i;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Illegal entries are reported even during a flush; the counter sticks at all-ones.
  always_comb begin
    illegal_d     = accept && !dec_ok;
    illegal_cnt_d = illegal_cnt_q;
    if (illegal_d && (illegal_cnt_q != {CNTW{1'b1}}))
      illegal_cnt_d = illegal_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      illegal_q     <= 1'b0;
      illegal_cnt_q <= '0;
    end else begin
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      illegal_q     <= illegal_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= '{a: bus.rs1_val, b: op_b, c: dec_c};
  end

  assign head          = mem_q[rd_ptr_q];
  assign bus.out_valid = (count_q != '0);
  assign bus.in1       = bus.out_valid ? head.a : '0;
  assign bus.in2       = bus.out_valid ? head.b : '0;
  assign bus.alu_c     = bus.out_valid ? head.c : 4'b0000;

  assign illegal_o     = illegal_q;
  assign illegal_cnt_o = illegal_cnt_q;
  assign count_o       = count_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch: decode table, FIFO order/wrap, backpressure,
// illegal-op counting with saturation, flush and asynchronous reset.
module tb_alu_dispatch;
  localparam int WIDTH = 64;
  localparam int DEPTH = 4;
  localparam int CNTW  = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            illegal;
  logic [CNTW-1:0] illegal_cnt;
  logic [2:0]      count;
  int              n_checks = 0;
  int              n_fail = 0;

  always #5 clk = ~clk;

  alu_dispatch_if #(.WIDTH(WIDTH)) bus ();

  alu_dispatch #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush),
    .bus          (bus.slave),
    .illegal_o    (illegal),
    .illegal_cnt_o(illegal_cnt),
    .count_o      (count)
  );

  // Decode vectors: aluop, funct3, b30, alu_src, rs1, rs2, imm -> alu_c, in2
  logic [1:0]  v_op  [7] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b10};
  logic [2:0]  v_f3  [7] = '{3'b111, 3'b110, 3'b000, 3'b000, 3'b011, 3'b010, 3'b110};
  logic        v_b30 [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic        v_src [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [63:0] v_rs1 [7] = '{64'd5, 64'd7, 64'd9, 64'd11, 64'd13, 64'd15, 64'd17};
  logic [63:0] v_rs2 [7] = '{64'h123, 64'h55, 64'h66, 64'h77, 64'h88, 64'h99, 64'hAA};
  logic [63:0] v_imm [7] = '{64'hFF, 64'hF0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1, 64'h20, 64'h2, 64'h3};
  logic [3:0]  v_c   [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0110, 4'b0001};
  logic [63:0] v_in2 [7] = '{64'hFF, 64'hF0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h77, 64'h20, 64'h99, 64'hAA};

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic b30,
                       input logic src, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] im);
    bus.in_valid   = 1'b1;
    bus.aluop      = op;
    bus.funct3     = f3;
    bus.funct7_b30 = b30;
    bus.alu_src    = src;
    bus.rs1_val    = a;
    bus.rs2_val    = b;
    bus.imm        = im;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    drive(2'b00, 3'b000, 1'b0, 1'b0, '0, '0, '0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks += 5;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
    if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
    if (illegal_cnt !== 8'd0 || illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got=%0d/%0b exp=0/0", illegal_cnt, illegal); end
    if (bus.in1 !== 64'd0 || bus.in2 !== 64'd0 || bus.alu_c !== 4'd0) begin n_fail++; $display("FAIL reset_operands got=%0h/%0h/%0h exp=0", bus.in1, bus.in2, bus.alu_c); end
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
    rst_n = 1'b1;
    $display("reset: out_valid=%0b count=%0d illegal_cnt=%0d", bus.out_valid, count, illegal_cnt);
  endtask

  task automatic test_sub();
    @(negedge clk);
    drive(2'b10, 3'b000, 1'b1, 1'b0, 64'd10, 64'd3, 64'd99);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL sub_no_bypass got=%0b exp=0", bus.out_valid); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_checks += 2;
    if (bus.out_valid !== 1'b1 || count !== 3'd1) begin n_fail++; $display("FAIL sub_valid got=%0b/%0d exp=1/1", bus.out_valid, count); end
    if (bus.in1 !== 64'd10 || bus.in2 !== 64'd3 || bus.alu_c !== 4'b0110) begin n_fail++; $display("FAIL sub_operands got=%0d/%0d/%b exp=10/3/0110", bus.in1, bus.in2, bus.alu_c); end
    $display("sub: in1=%0d in2=%0d alu_c=%b", bus.in1, bus.in2, bus.alu_c);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || count !== 3'd0 || bus.in2 !== 64'd0) begin n_fail++; $display("FAIL sub_pop got=%0b/%0d/%0h exp=0/0/0", bus.out_valid, count, bus.in2); end
  endtask

  task automatic test_decode();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(v_op[i], v_f3[i], v_b30[i], v_src[i], v_rs1[i], v_rs2[i], v_imm[i]);
      @(negedge clk);
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.in1 !== v_rs1[i] || bus.in2 !== v_in2[i] || bus.alu_c !== v_c[i]) begin
        n_fail++;
        $display("FAIL decode_%0d got=%0b/%0h/%0h/%b exp=1/%0h/%0h/%b", i, bus.out_valid, bus.in1, bus.in2, bus.alu_c, v_rs1[i], v_in2[i], v_c[i]);
      end
      $display("decode %0d: aluop=%b funct3=%b alu_c=%b in2=%0h", i, v_op[i], v_f3[i], bus.alu_c, bus.in2);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
    end
    n_checks++;
    if (count !== 3'd0) begin n_fail++; $display("FAIL decode_drained got=%0d exp=0", count); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive(2'b00, 3'b000, 1'b0, 1'b0, 64'hA1, 64'h1, 64'h0);
    @(negedge clk);
    n_checks++;
    if (count !== 3'd1 || bus.in1 !== 64'hA1) begin n_fail++; $display("FAIL b2b_first got=%0d/%0h exp=1/a1", count, bus.in1); end
    drive(2'b00, 3'b000, 1'b0, 1'b0, 64'hB2, 64'h2, 64'h0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (count !== 3'd1 || bus.in1 !== 64'hB2) begin n_fail++; $display("FAIL b2b_second got=%0d/%0h exp=1/b2", count, bus.in1); end
    drive(2'b00, 3'b000, 1'b0, 1'b0, 64'hC3, 64'h3, 64'h0);
    @(negedge clk);
    n_checks++;
    if (count !== 3'd1 || bus.in1 !== 64'hC3) begin n_fail++; $display("FAIL b2b_third got=%0d/%0h exp=1/c3", count, bus.in1); end
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_checks++;
    if (count !== 3'd0) begin n_fail++; $display("FAIL b2b_drain got=%0d exp=0", count); end
    $display("back_to_back: push+pop held count at 1");
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      drive(2'b00, 3'b000, 1'b0, 1'b0, 64'h100 + 64'(i), 64'h200 + 64'(i), 64'h0);
    end
    @(negedge clk);
    drive(2'b00, 3'b000, 1'b0, 1'b0, 64'h1FF, 64'h2FF, 64'h0);
    n_checks += 2;
    if (count !== 3'd4 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full got=%0d/%0b exp=4/0", count, bus.in_ready); end
    if (bus.in1 !== 64'h100) begin n_fail++; $display("FAIL fill_head got=%0h exp=100", bus.in1); end
    @(negedge clk);
    n_checks++;
    if (count !== 3'd4 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_hold got=%0d/%0b exp=4/0", count, bus.in_ready); end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (bus.in1 !== 64'h100 + 64'(i) || bus.in2 !== 64'h200 + 64'(i)) begin
        n_fail++;
        $display("FAIL fill_order_%0d got=%0h/%0h exp=%0h/%0h", i, bus.in1, bus.in2, 64'h100 + 64'(i), 64'h200 + 64'(i));
      end
      $display("drain %0d: in1=%0h in2=%0h", i, bus.in1, bus.in2);
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    n_checks++;
    if (count !== 3'd0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL fill_empty got=%0d/%0b exp=0/0", count, bus.out_valid); end
    drive(2'b00, 3'b000, 1'b0, 1'b0, 64'h1FF, 64'h2FF, 64'h0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_checks++;
    if (count !== 3'd1 || bus.in1 !== 64'h1FF) begin n_fail++; $display("FAIL fill_wrap got=%0d/%0h exp=1/1ff", count, bus.in1); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_illegal();
    @(negedge clk);
    drive(2'b11, 3'b000, 1'b0, 1'b0, 64'd1, 64'd2, 64'd3);
    @(negedge clk);
    drive(2'b10, 3'b001, 1'b0, 1'b0, 64'd1, 64'd2, 64'd3);
    n_checks++;
    if (illegal !== 1'b1 || illegal_cnt !== 8'd1 || count !== 3'd0) begin n_fail++; $display("FAIL illegal_first got=%0b/%0d/%0d exp=1/1/0", illegal, illegal_cnt, count); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_checks++;
    if (illegal !== 1'b1 || illegal_cnt !== 8'd2 || count !== 3'd0) begin n_fail++; $display("FAIL illegal_second got=%0b/%0d/%0d exp=1/2/0", illegal, illegal_cnt, count); end
    @(negedge clk);
    n_checks++;
    if (illegal !== 1'b0 || illegal_cnt !== 8'd2) begin n_fail++; $display("FAIL illegal_pulse_end got=%0b/%0d exp=0/2", illegal, illegal_cnt); end
    $display("illegal: cnt=%0d", illegal_cnt);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(2'b00, 3'b000, 1'b0, 1'b0, 64'h300 + 64'(i), 64'h0, 64'h0);
    end
    @(negedge clk);
    n_checks++;
    if (count !== 3'd3) begin n_fail++; $display("FAIL flush_pre got=%0d exp=3", count); end
    drive(2'b00, 3'b000, 1'b0, 1'b0, 64'h3FF, 64'h0, 64'h0);
    flush = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (count !== 3'd0 || bus.out_valid !== 1'b0 || bus.in1 !== 64'd0) begin n_fail++; $display("FAIL flush_clear got=%0d/%0b/%0h exp=0/0/0", count, bus.out_valid, bus.in1); end
    drive(2'b11, 3'b000, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    n_checks++;
    if (illegal !== 1'b1 || illegal_cnt !== 8'd3 || count !== 3'd0) begin n_fail++; $display("FAIL flush_illegal got=%0b/%0d/%0d exp=1/3/0", illegal, illegal_cnt, count); end
    @(negedge clk);
    n_checks++;
    if (count !== 3'd0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_lost got=%0d/%0b exp=0/0", count, bus.out_valid); end
    $display("flush: count=%0d illegal_cnt=%0d", count, illegal_cnt);
  endtask

  task automatic test_saturate();
    int exp_cnt;
    @(negedge clk);
    drive(2'b11, 3'b101, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      exp_cnt = (3 + i > 255) ? 255 : 3 + i;
      n_checks++;
      if (illegal_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL saturate_%0d got=%0d exp=%0d", i, illegal_cnt, exp_cnt); end
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (count !== 3'd0) begin n_fail++; $display("FAIL saturate_count got=%0d exp=0", count); end
    $display("saturate: illegal_cnt=%0d after 300 illegal entries", illegal_cnt);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(2'b00, 3'b000, 1'b0, 1'b0, 64'h500 + 64'(i), 64'h0, 64'h0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_checks++;
    if (count !== 3'd2) begin n_fail++; $display("FAIL areset_pre got=%0d exp=2", count); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || count !== 3'd0 || illegal_cnt !== 8'd0 || bus.in1 !== 64'd0) begin
      n_fail++;
      $display("FAIL areset_now got=%0b/%0d/%0d/%0h exp=0/0/0/0", bus.out_valid, count, illegal_cnt, bus.in1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (count !== 3'd0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_dropped got=%0d/%0b exp=0/0", count, bus.out_valid); end
    $display("async_reset: count=%0d illegal_cnt=%0d", count, illegal_cnt);
  endtask

  initial begin
    test_reset();
    test_sub();
    test_decode();
    test_back_to_back();
    test_fill();
    test_illegal();
    test_flush();
    test_saturate();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
